id_ex_operand_stage: RTL
========================

# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding front end of the EX stage. It captures decoded operands and control from ID, inserts bubbles on load-use hazards and flushes, and drives the resolved `A`, `B` and `aluOperation` directly into the ALU. Operands are forwarded from the EX/MEM and MEM/WB stages.

## Interface
- `WIDTH`, 32, datapath width.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `readData1`, `readData2`  input  WIDTH  register-file operands from ID.
- `signExtImm`  input  WIDTH  sign-extended immediate from ID.
- `rsIn`, `rtIn`, `rdIn`  input  5  register numbers from ID.
- `aluOperationIn`  input  3  ALU op code from ID (000 add, 001 sub, 010 and, 011 or, 100 slt).
- `aluSrcIn`, `regDstIn`, `regWriteIn`, `memReadIn`, `memWriteIn`, `memToRegIn`  input  1  control from ID.
- `stall`  input  1  hold the stage (downstream busy).
- `flush`  input  1  squash the ID instruction (taken branch/jump).
- `exMemRegWrite`  input  1  EX/MEM writes a register.
- `exMemRd`  input  5  EX/MEM destination.
- `exMemAluOut`  input  WIDTH  EX/MEM result.
- `memWbRegWrite`  input  1  MEM/WB writes a register.
- `memWbRd`  input  5  MEM/WB destination.
- `memWbWriteData`  input  WIDTH  MEM/WB result.
- `A`, `B`  output  WIDTH  ALU operands.
- `aluOperation`  output  3  registered ALU op.
- `storeData`  output  WIDTH  forwarded rt value for stores.
- `writeReg`  output  5  destination register (rd if regDst, else rt).
- `regWrite`, `memRead`, `memWrite`, `memToReg`  output  1  registered control.
- `loadUseHazard`  output  1  to hazard logic: stall PC and IF/ID.

## Operation
- Registered fields: rs, rt, writeReg, readData1, readData2, signExtImm, aluOperation, aluSrc, regWrite, memRead, memWrite, memToReg.
- `writeReg` is computed at capture: `regDstIn ? rdIn : rtIn`.
- `loadUseHazard` (combinational) = `memRead & (rt != 0) & (rt == rsIn | rt == rtIn)`, using the registered rt.
- Update priority at each clock edge:
  1. `flush`: bubble.
  2. `stall`: hold all registers.
  3. `loadUseHazard`: bubble.
  4. Otherwise load from ID.
- Bubble: all control bits, `aluOperation`, rs, rt and writeReg are cleared to 0. Data fields are don't-care; they are cleared to 0.
- Forwarding for operand X ∈ {rs, rt} (combinational):
  - If `exMemRegWrite & exMemRd != 0 & exMemRd == X`, use `exMemAluOut`.
  - Else if `memWbRegWrite & memWbRd != 0 & memWbRd == X`, use `memWbWriteData`.
  - Else use the registered readData.
  - EX/MEM always takes priority over MEM/WB.
- `A` = forwarded rs value.
- `storeData` = forwarded rt value.
- `B` = `aluSrc ? signExtImm : forwarded rt`.
- Register $0 is never forwarded; its registered value is passed through unchanged.

## Timing
- Reset (`rst` = 0, asynchronous): every register is 0. As a result `A` = `B` = `storeData` = 0, `aluOperation` = 000, `writeReg` = 0, all control outputs = 0, and `loadUseHazard` = 0.
- Reset release takes effect on the first rising edge with `rst` = 1.
- ID → outputs latency: 1 cycle.
- Forwarding muxes are zero-cycle: changes on the EX/MEM or MEM/WB inputs appear at `A`/`B` in the same cycle.
- Load-use: with a lw in this stage and a dependent instruction in ID, `loadUseHazard` = 1 during that cycle. The next edge inserts one bubble. In the following cycle the lw is in MEM and the hazard drops, so the dependent instruction loads on the edge after that. The one-cycle gap is thereby guaranteed.
- `flush` together with `stall`: flush wins and a bubble is inserted.
- `stall` during a hazard: hold; the hazard persists and is resolved after the stall ends.
- Reset mid-operation clears the in-flight instruction; no partial state survives.

## Test plan
- Reset: hold `rst` = 0 with random inputs → all outputs 0 and `loadUseHazard` = 0. Release, then load add $3,$1,$2 with readData1 = 5, readData2 = 7 → next cycle `A` = 5, `B` = 7, `aluOperation` = 000, `writeReg` = 3.
- EX/MEM forward: registered rs = 4, `exMemRegWrite` = 1, `exMemRd` = 4, `exMemAluOut` = 0x10 → `A` = 0x10 in the same cycle.
- Double match: `exMemRd` = `memWbRd` = rt = 6, both writes active, values 0xAA and 0xBB, `aluSrc` = 0 → `B` = 0xAA. With `aluSrc` = 1 and imm = 0xFFFFFFFC → `B` = 0xFFFFFFFC and `storeData` = 0xAA.
- $0 guard: rs = 0, `exMemRd` = 0, `exMemRegWrite` = 1, `exMemAluOut` = 9 → `A` = registered readData1 (0).
- Load-use: lw $2 in this stage, ID presents rsIn = 2 → `loadUseHazard` = 1. Next cycle all control is 0 (bubble) and `loadUseHazard` = 0. On the following edge the dependent instruction loads.
- Flush/stall: with `stall` = 1 the outputs hold across 3 edges. Asserting `flush` with `stall` = 1 gives a bubble on the next edge: `regWrite` = 0 and `memWrite` = 0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Brief    : ID/EX pipeline register with load-use bubble insertion and
//            EX/MEM + MEM/WB operand forwarding in front of the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic [WIDTH-1:0] signExtImm,
  input  logic [4:0]       rsIn,
  input  logic [4:0]       rtIn,
  input  logic [4:0]       rdIn,
  input  logic [2:0]       aluOperationIn,
  input  logic             aluSrcIn,
  input  logic             regDstIn,
  input  logic             regWriteIn,
  input  logic             memReadIn,
  input  logic             memWriteIn,
  input  logic             memToRegIn,
  input  logic             stall,
  input  logic             flush,
  input  logic             exMemRegWrite,
  input  logic [4:0]       exMemRd,
  input  logic [WIDTH-1:0] exMemAluOut,
  input  logic             memWbRegWrite,
  input  logic [4:0]       memWbRd,
  input  logic [WIDTH-1:0] memWbWriteData,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       aluOperation,
  output logic [WIDTH-1:0] storeData,
  output logic [4:0]       writeReg,
  output logic             regWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             memToReg,
  output logic             loadUseHazard
);

  // Pipeline registers
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_writeReg;
  logic [WIDTH-1:0] r_readData1;
  logic [WIDTH-1:0] r_readData2;
  logic [WIDTH-1:0] r_signExtImm;
  logic [2:0]       r_aluOperation;
  logic             r_aluSrc;
  logic             r_regWrite;
  logic             r_memRead;
  logic             r_memWrite;
  logic             r_memToReg;

  // Combinational helpers
  logic             w_loadUseHazard;
  logic [WIDTH-1:0] w_fwdRs;
  logic [WIDTH-1:0] w_fwdRt;

  // A load in this stage whose destination feeds the instruction in ID
  assign w_loadUseHazard = r_memRead & (r_rt != 5'd0) &
                           ((r_rt == rsIn) | (r_rt == rtIn));

  // Capture from ID; flush beats stall, stall beats the load-use bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs           <= '0;
      r_rt           <= '0;
      r_writeReg     <= '0;
      r_readData1    <= '0;
      r_readData2    <= '0;
      r_signExtImm   <= '0;
      r_aluOperation <= '0;
      r_aluSrc       <= 1'b0;
      r_regWrite     <= 1'b0;
      r_memRead      <= 1'b0;
      r_memWrite     <= 1'b0;
      r_memToReg     <= 1'b0;
    end else if (flush || (!stall && w_loadUseHazard)) begin
      // Bubble: a harmless no-op with no register write or memory access
      r_rs           <= '0;
      r_rt           <= '0;
      r_writeReg     <= '0;
      r_readData1    <= '0;
      r_readData2    <= '0;
      r_signExtImm   <= '0;
      r_aluOperation <= '0;
      r_aluSrc       <= 1'b0;
      r_regWrite     <= 1'b0;
      r_memRead      <= 1'b0;
      r_memWrite     <= 1'b0;
      r_memToReg     <= 1'b0;
    end else if (!stall) begin
      r_rs           <= rsIn;
      r_rt           <= rtIn;
      r_writeReg     <= regDstIn ? rdIn : rtIn;
      r_readData1    <= readData1;
      r_readData2    <= readData2;
      r_signExtImm   <= signExtImm;
      r_aluOperation <= aluOperationIn;
      r_aluSrc       <= aluSrcIn;
      r_regWrite     <= regWriteIn;
      r_memRead      <= memReadIn;
      r_memWrite     <= memWriteIn;
      r_memToReg     <= memToRegIn;
    end
  end

  // Operand forwarding: youngest producer (EX/MEM) wins, $0 is never forwarded
  always_comb begin
    w_fwdRs = r_readData1;
    if (exMemRegWrite && (exMemRd != 5'd0) && (exMemRd == r_rs))
      w_fwdRs = exMemAluOut;
    else if (memWbRegWrite && (memWbRd != 5'd0) && (memWbRd == r_rs))
      w_fwdRs = memWbWriteData;

    w_fwdRt = r_readData2;
    if (exMemRegWrite && (exMemRd != 5'd0) && (exMemRd == r_rt))
      w_fwdRt = exMemAluOut;
    else if (memWbRegWrite && (memWbRd != 5'd0) && (memWbRd == r_rt))
      w_fwdRt = memWbWriteData;
  end

  assign A             = w_fwdRs;
  assign B             = r_aluSrc ? r_signExtImm : w_fwdRt;
  assign storeData     = w_fwdRt;
  assign aluOperation  = r_aluOperation;
  assign writeReg      = r_writeReg;
  assign regWrite      = r_regWrite;
  assign memRead       = r_memRead;
  assign memWrite      = r_memWrite;
  assign memToReg      = r_memToReg;
  assign loadUseHazard = w_loadUseHazard;

endmodule
`default_nettype wire
